idu_stage: RTL and testbench
============================

// Module: idu_stage
// PURPOSE
//  Registered decode stage: replaces the purely combinational decoder between IF and EX.
//  - Accepts {inst, pc} from fetch over a valid/ready handshake.
//  - Decodes controls, register indices, ALU op and the sign-extended immediate.
//  - Presents the result one cycle later over a valid/ready handshake to EX.
//  - Adds a trap FSM: after an ecall, ebreak or illegal instruction, it stops accepting until flush.
// PARAMETERS
//  RF_SIZE     5   register index width
//  XLEN        64  data/immediate/pc width
//  EN_RV64     1   1: opcodes 0x3b/0x1b (W-ops) legal; 0: they decode as illegal
//  TRAP_HALT   1   1: enter HALT after trap/illegal; 0: flag only, keep running
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        asynchronous active-low reset
//  flush_i        in   1        kill held entry, leave HALT
//  inst_valid_i   in   1        fetch has inst
//  inst_ready_o   out  1        stage can accept
//  inst_i         in   32       instruction word
//  pc_i           in   XLEN     instruction pc
//  dec_valid_o    out  1        decoded bundle valid
//  dec_ready_i    in   1        EX accepts bundle
//  pc_o           out  XLEN     registered pc
//  rd_o/rs1_o/rs2_o out RF_SIZE register indices
//  rd_en_o/rs1_en_o/rs2_en_o out 1  register-use enables
//  memread_o/memwrite_o out 1   load/store
//  memwid_o/brty_o out 3        funct3
//  alu_op_o       out  4        ALU op (package enum)
//  alu_src2_imm_o out  1        ALU B operand = imm
//  branch_o/jal_o/jalr_o/auipc_o out 1  flow controls
//  imm_o          out  XLEN     sign-extended immediate (I/S/B/U/J by opcode; 0 for R/Env)
//  illegal_o      out  1        decode error
//  env_o          out  2        [0]=ecall [1]=ebreak
//  halted_o       out  1        FSM in HALT
// BEHAVIOUR
//  - Reset: all outputs 0 (dec_valid_o=0, halted_o=0); FSM=RUN.
//  - Handshake:
//    - Accept = inst_valid_i & inst_ready_o.
//    - inst_ready_o = (state==RUN) & (!dec_valid_o | dec_ready_i) & !flush_i.
//    - Latency: exactly 1 cycle from accept to dec_valid_o.
//    - The bundle is held stable while dec_valid_o & !dec_ready_i.
//    - Back-to-back accept each cycle when dec_ready_i=1; no bubbles.
//  - FSM states: RUN, HALT.
//    - RUN -> HALT when an accepted inst is illegal or env!=0, and TRAP_HALT=1.
//    - The trapping inst is still delivered downstream with its flags.
//    - HALT: inst_ready_o=0; a held bundle still drains normally.
//    - HALT -> RUN only on flush_i.
//  - flush_i (priority over everything):
//    - Next cycle: dec_valid_o=0, FSM=RUN.
//    - No accept in the flush cycle.
//  - Illegal:
//    - Unknown opcode.
//    - Env with funct12 not in {0,1}.
//    - Branch funct3 in {010,011}.
//    - W-op when EN_RV64=0.
//    - Illegal insts: all enables/mem/flow controls 0, alu_op=ADD.
//  - ALU op encoding:
//    - ADD0 SUB1 OR2 AND3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 COPY_B10 ADDW11 SUBW12 SLLW13 SRLW14 SRAW15.
//    - Shift-immediate arithmetic select uses inst[30]; shamt taken from imm low bits by EX.
//  - Immediate: built at full XLEN from sign bit inst[31]; U-type = {inst[31:12],12'b0} sign-extended.
//  - Async reset mid-transfer: bundle dropped, FSM=RUN; fetch must replay.
// STRUCTURE
//  - Package idu_pkg: opcode localparams; ALU op enum (4b); branch-type enum; imm-type enum {I,S,B,U,J,NONE}.
//  - Sub-module idu_core: purely combinational inst->bundle + imm + illegal; idu_stage adds the pipe register, handshake and FSM.
// TESTING
//  1. 0x00500093 (addi x1,x0,5), dec_ready_i=1 -> next cycle dec_valid_o=1, rd=1, rd_en=1, rs1_en=1, imm=5, alu_op=0, alu_src2_imm=1.
//  2. 0xFE208EE3 (beq x1,x2,-4) with dec_ready_i=0 for 3 cycles -> bundle stable; imm=0xFFFF_FFFF_FFFF_FFFC; inst_ready_o=0 until release.
//  3. 0x123452B7 (lui x5) -> imm=0x0000_0000_1234_5000, alu_op=10.
//     0x002081BB (addw x3,x1,x2) -> alu_op=11 with EN_RV64=1; illegal_o=1 with EN_RV64=0.
//  4. 0x00000073 (ecall) then 0x00500093 offered -> env_o=01, halted_o=1, addi not accepted.
//     Pulse flush_i -> dec_valid_o=0 and halted_o=0 next cycle; addi accepted the cycle after.
//  5. 0xFFFFFFFF -> illegal_o=1, all controls 0, HALT entered.
//     0x00100073 -> env_o=10.
//  6. Stream of 8 addi with dec_ready_i=1 -> 8 consecutive valid cycles.
//     Assert rst_n=0 mid-stream -> dec_valid_o=0 immediately (async).

Source files
------------

// File: rtl/idu_pkg.sv
// Shared definitions for the registered instruction decode stage.
package idu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6f;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP_IMM_W = 7'h1b;
    localparam logic [6:0] OPC_OP_W     = 7'h3b;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,  ALU_SUB  = 4'd1,  ALU_OR   = 4'd2,  ALU_AND  = 4'd3,
        ALU_XOR    = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
        ALU_SLT    = 4'd8,  ALU_SLTU = 4'd9,  ALU_COPY_B = 4'd10, ALU_ADDW = 4'd11,
        ALU_SUBW   = 4'd12, ALU_SLLW = 4'd13, ALU_SRLW = 4'd14, ALU_SRAW = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100,
        BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
    } br_type_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    // Stage state: RUN accepts new instructions, HALT waits for a flush.
    typedef enum logic {ST_RUN, ST_HALT} state_e;

    // Decoded control bundle (everything except pc, register indices and imm).
    typedef struct packed {
        logic       rd_en;
        logic       rs1_en;
        logic       rs2_en;
        logic       memread;
        logic       memwrite;
        logic [2:0] memwid;
        logic [2:0] brty;
        alu_op_e    alu_op;
        logic       alu_src2_imm;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       auipc;
        logic       illegal;
        logic [1:0] env;
    } ctrl_t;

    function automatic logic br_legal(input logic [2:0] funct3);
        return funct3 inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};
    endfunction

    // Integer ALU op from funct3; alt (inst[30]) picks SUB only for register ops, SRA for both.
    function automatic alu_op_e alu_int(input logic [2:0] funct3, input logic alt,
                                        input logic is_reg);
        case (funct3)
            3'd0:    return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // 32-bit word ALU op for the W opcodes; unlisted funct3 values fall back to ADDW.
    function automatic alu_op_e alu_word(input logic [2:0] funct3, input logic alt,
                                         input logic is_reg);
        case (funct3)
            3'd1:    return ALU_SLLW;
            3'd5:    return alt ? ALU_SRAW : ALU_SRLW;
            default: return (is_reg && alt && funct3 == 3'd0) ? ALU_SUBW : ALU_ADDW;
        endcase
    endfunction

endpackage

// File: rtl/idu_core.sv
// Combinational decoder: instruction word -> control bundle, indices, immediate.
module idu_core
    import idu_pkg::*;
#(
    parameter int RF_SIZE = 5,
    parameter int XLEN    = 64,
    parameter bit EN_RV64 = 1'b1
) (
    input  logic [31:0]        inst,
    output ctrl_t              ctrl,
    output logic [RF_SIZE-1:0] rd,
    output logic [RF_SIZE-1:0] rs1,
    output logic [RF_SIZE-1:0] rs2,
    output logic [XLEN-1:0]    imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] funct12;
    logic        alt;
    imm_type_e   imm_type;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign funct12 = inst[31:20];
    assign alt     = inst[30];

    assign rd  = RF_SIZE'(inst[11:7]);
    assign rs1 = RF_SIZE'(inst[19:15]);
    assign rs2 = RF_SIZE'(inst[24:20]);

    // Opcode decode; an illegal word collapses to an all-zero bundle with only the flag set.
    always_comb begin
        ctrl     = '0;
        imm_type = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                ctrl.rd_en = 1'b1; ctrl.alu_op = ALU_COPY_B; ctrl.alu_src2_imm = 1'b1;
                imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.rd_en = 1'b1; ctrl.alu_src2_imm = 1'b1; ctrl.auipc = 1'b1;
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                ctrl.rd_en = 1'b1; ctrl.alu_src2_imm = 1'b1; ctrl.jal = 1'b1;
                imm_type = IMM_J;
            end
            OPC_JALR: begin
                ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.alu_src2_imm = 1'b1;
                ctrl.jalr = 1'b1; imm_type = IMM_I;
            end
            OPC_BRANCH: begin
                if (br_legal(funct3)) begin
                    ctrl.rs1_en = 1'b1; ctrl.rs2_en = 1'b1; ctrl.branch = 1'b1;
                    ctrl.brty = funct3; ctrl.alu_op = ALU_SUB; imm_type = IMM_B;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.memread = 1'b1;
                ctrl.memwid = funct3; ctrl.alu_src2_imm = 1'b1; imm_type = IMM_I;
            end
            OPC_STORE: begin
                ctrl.rs1_en = 1'b1; ctrl.rs2_en = 1'b1; ctrl.memwrite = 1'b1;
                ctrl.memwid = funct3; ctrl.alu_src2_imm = 1'b1; imm_type = IMM_S;
            end
            OPC_OP_IMM: begin
                ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.alu_src2_imm = 1'b1;
                ctrl.alu_op = alu_int(funct3, alt, 1'b0); imm_type = IMM_I;
            end
            OPC_OP: begin
                ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.rs2_en = 1'b1;
                ctrl.alu_op = alu_int(funct3, alt, 1'b1);
            end
            OPC_OP_IMM_W: begin
                if (EN_RV64) begin
                    ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.alu_src2_imm = 1'b1;
                    ctrl.alu_op = alu_word(funct3, alt, 1'b0); imm_type = IMM_I;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_OP_W: begin
                if (EN_RV64) begin
                    ctrl.rd_en = 1'b1; ctrl.rs1_en = 1'b1; ctrl.rs2_en = 1'b1;
                    ctrl.alu_op = alu_word(funct3, alt, 1'b1);
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (funct12 == 12'd0)      ctrl.env = 2'b01;
                else if (funct12 == 12'd1) ctrl.env = 2'b10;
                else                       ctrl.illegal = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            imm_type     = IMM_NONE;
        end
    end

    // Immediate assembly at full XLEN, always sign-extended from inst[31].
    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            IMM_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: one-entry pipe register between fetch and execute,
// with a RUN/HALT trap FSM that stops intake after ecall/ebreak/illegal until flush.
module idu_stage
    import idu_pkg::*;
#(
    parameter int RF_SIZE   = 5,
    parameter int XLEN      = 64,
    parameter bit EN_RV64   = 1'b1,
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               inst_valid_i,
    output logic               inst_ready_o,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    pc_i,
    output logic               dec_valid_o,
    input  logic               dec_ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [RF_SIZE-1:0] rd_o,
    output logic [RF_SIZE-1:0] rs1_o,
    output logic [RF_SIZE-1:0] rs2_o,
    output logic               rd_en_o,
    output logic               rs1_en_o,
    output logic               rs2_en_o,
    output logic               memread_o,
    output logic               memwrite_o,
    output logic [2:0]         memwid_o,
    output logic [2:0]         brty_o,
    output logic [3:0]         alu_op_o,
    output logic               alu_src2_imm_o,
    output logic               branch_o,
    output logic               jal_o,
    output logic               jalr_o,
    output logic               auipc_o,
    output logic [XLEN-1:0]    imm_o,
    output logic               illegal_o,
    output logic [1:0]         env_o,
    output logic               halted_o
);

    // Handshake: a side transfers on a cycle where its valid and ready are both high.
    // Upstream is ready when running, not flushing, and the register is empty or draining.
    // The downstream bundle stays frozen while dec_valid_o is high and dec_ready_i is low.

    ctrl_t              ctrl_d, ctrl_q;
    logic [RF_SIZE-1:0] rd_d, rs1_d, rs2_d;
    logic [XLEN-1:0]    imm_d;
    state_e             state_q, state_d;
    logic               accept, trap;

    idu_core #(.RF_SIZE(RF_SIZE), .XLEN(XLEN), .EN_RV64(EN_RV64)) u_core (
        .inst (inst_i),
        .ctrl (ctrl_d),
        .rd   (rd_d),
        .rs1  (rs1_d),
        .rs2  (rs2_d),
        .imm  (imm_d)
    );

    assign inst_ready_o = (state_q == ST_RUN) & (~dec_valid_o | dec_ready_i) & ~flush_i;
    assign accept       = inst_valid_i & inst_ready_o;
    assign trap         = ctrl_d.illegal | (ctrl_d.env != 2'b00);
    assign halted_o     = (state_q == ST_HALT);

    // Next-state: flush always returns to RUN; an accepted trapping inst enters HALT.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && accept && trap && TRAP_HALT) begin
            state_d = ST_HALT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Output valid: set on accept, cleared on drain or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            dec_valid_o <= 1'b0;
        else if (flush_i)      dec_valid_o <= 1'b0;
        else if (accept)       dec_valid_o <= 1'b1;
        else if (dec_ready_i)  dec_valid_o <= 1'b0;
    end

    // Bundle register: loads only on accept so a stalled bundle stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            pc_o   <= '0;
            rd_o   <= '0;
            rs1_o  <= '0;
            rs2_o  <= '0;
            imm_o  <= '0;
        end else if (accept) begin
            ctrl_q <= ctrl_d;
            pc_o   <= pc_i;
            rd_o   <= rd_d;
            rs1_o  <= rs1_d;
            rs2_o  <= rs2_d;
            imm_o  <= imm_d;
        end
    end

    assign rd_en_o        = ctrl_q.rd_en;
    assign rs1_en_o       = ctrl_q.rs1_en;
    assign rs2_en_o       = ctrl_q.rs2_en;
    assign memread_o      = ctrl_q.memread;
    assign memwrite_o     = ctrl_q.memwrite;
    assign memwid_o       = ctrl_q.memwid;
    assign brty_o         = ctrl_q.brty;
    assign alu_op_o       = ctrl_q.alu_op;
    assign alu_src2_imm_o = ctrl_q.alu_src2_imm;
    assign branch_o       = ctrl_q.branch;
    assign jal_o          = ctrl_q.jal;
    assign jalr_o         = ctrl_q.jalr;
    assign auipc_o        = ctrl_q.auipc;
    assign illegal_o      = ctrl_q.illegal;
    assign env_o          = ctrl_q.env;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: directed steps then randomized traffic against a reference model.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        dec_ready_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [63:0] pc_i = '0;

    logic        inst_ready_o, dec_valid_o, halted_o;
    logic [63:0] pc_o, imm_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic        rd_en_o, rs1_en_o, rs2_en_o, memread_o, memwrite_o;
    logic [2:0]  memwid_o, brty_o;
    logic [3:0]  alu_op_o;
    logic        alu_src2_imm_o, branch_o, jal_o, jalr_o, auipc_o, illegal_o;
    logic [1:0]  env_o;

    logic        r32_inst_ready, r32_dec_valid, r32_halted;
    logic [63:0] r32_pc, r32_imm;
    logic [4:0]  r32_rd, r32_rs1, r32_rs2;
    logic        r32_rd_en, r32_rs1_en, r32_rs2_en, r32_memread, r32_memwrite;
    logic [2:0]  r32_memwid, r32_brty;
    logic [3:0]  r32_alu_op;
    logic        r32_src2, r32_branch, r32_jal, r32_jalr, r32_auipc, r32_illegal;
    logic [1:0]  r32_env;

    idu_stage dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .pc_o(pc_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_en_o(rd_en_o), .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o),
        .memwid_o(memwid_o), .brty_o(brty_o), .alu_op_o(alu_op_o),
        .alu_src2_imm_o(alu_src2_imm_o), .branch_o(branch_o), .jal_o(jal_o),
        .jalr_o(jalr_o), .auipc_o(auipc_o), .imm_o(imm_o),
        .illegal_o(illegal_o), .env_o(env_o), .halted_o(halted_o)
    );

    idu_stage #(.EN_RV64(1'b0)) dut_rv32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(r32_inst_ready),
        .inst_i(inst_i), .pc_i(pc_i),
        .dec_valid_o(r32_dec_valid), .dec_ready_i(dec_ready_i), .pc_o(r32_pc),
        .rd_o(r32_rd), .rs1_o(r32_rs1), .rs2_o(r32_rs2),
        .rd_en_o(r32_rd_en), .rs1_en_o(r32_rs1_en), .rs2_en_o(r32_rs2_en),
        .memread_o(r32_memread), .memwrite_o(r32_memwrite),
        .memwid_o(r32_memwid), .brty_o(r32_brty), .alu_op_o(r32_alu_op),
        .alu_src2_imm_o(r32_src2), .branch_o(r32_branch), .jal_o(r32_jal),
        .jalr_o(r32_jalr), .auipc_o(r32_auipc), .imm_o(r32_imm),
        .illegal_o(r32_illegal), .env_o(r32_env), .halted_o(r32_halted)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic        rd_en, rs1_en, rs2_en, memread, memwrite;
        logic [2:0]  memwid, brty;
        logic [3:0]  alu;
        logic        src2, branch, jal, jalr, auipc, illegal;
        logic [1:0]  env;
        logic [63:0] imm;
    } exp_t;

    exp_t exp_q[$];
    bit   m_halt = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decoder built from the ISA field rules using plain arithmetic on the word.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input bit rv64);
        exp_t e, z;
        logic signed [63:0] sw, s20, s11;
        logic [63:0] ii, is, ib, iu, ij;
        logic [2:0]  f3;
        int alu_tab[8];
        alu_tab = '{0, 5, 8, 9, 4, 6, 2, 3};
        e = '{default: '0};
        e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        f3  = w[14:12];
        sw  = {{32{w[31]}}, w};
        s20 = sw >>> 20;
        s11 = sw >>> 11;
        ii = s20;
        iu = sw & ~64'hFFF;
        is = (s20 & ~64'h1F) | ((w >> 7) & 64'h1F);
        ib = (is & ~64'h801) | (64'(w[7]) << 11);
        ij = (s11 & ~64'hFFFFF) | (w & 64'hFF000) | (64'(w[20]) << 11) | (((w >> 21) & 64'h3FF) << 1);
        case (w[6:0])
            7'h37: begin e.rd_en = 1; e.src2 = 1; e.alu = 10; e.imm = iu; end
            7'h17: begin e.rd_en = 1; e.src2 = 1; e.auipc = 1; e.imm = iu; end
            7'h6f: begin e.rd_en = 1; e.src2 = 1; e.jal = 1; e.imm = ij; end
            7'h67: begin e.rd_en = 1; e.rs1_en = 1; e.src2 = 1; e.jalr = 1; e.imm = ii; end
            7'h63: begin
                if (f3 == 3'b010 || f3 == 3'b011) e.illegal = 1;
                else begin e.rs1_en = 1; e.rs2_en = 1; e.branch = 1; e.brty = f3; e.alu = 1; e.imm = ib; end
            end
            7'h03: begin e.rd_en = 1; e.rs1_en = 1; e.memread = 1; e.memwid = f3; e.src2 = 1; e.imm = ii; end
            7'h23: begin e.rs1_en = 1; e.rs2_en = 1; e.memwrite = 1; e.memwid = f3; e.src2 = 1; e.imm = is; end
            7'h13: begin
                e.rd_en = 1; e.rs1_en = 1; e.src2 = 1; e.imm = ii; e.alu = 4'(alu_tab[f3]);
                if (f3 == 3'd5 && w[30]) e.alu = 7;
            end
            7'h33: begin
                e.rd_en = 1; e.rs1_en = 1; e.rs2_en = 1; e.alu = 4'(alu_tab[f3]);
                if (f3 == 3'd5 && w[30]) e.alu = 7;
                if (f3 == 3'd0 && w[30]) e.alu = 1;
            end
            7'h1b, 7'h3b: begin
                if (!rv64) e.illegal = 1;
                else begin
                    e.rd_en = 1; e.rs1_en = 1;
                    if (w[6:0] == 7'h1b) begin e.src2 = 1; e.imm = ii; end
                    else e.rs2_en = 1;
                    if (f3 == 3'd1)      e.alu = 13;
                    else if (f3 == 3'd5) e.alu = w[30] ? 4'd15 : 4'd14;
                    else if (f3 == 3'd0 && w[30] && w[6:0] == 7'h3b) e.alu = 12;
                    else                 e.alu = 11;
                end
            end
            7'h73: begin
                if (w[31:20] == 12'd0)      e.env = 2'b01;
                else if (w[31:20] == 12'd1) e.env = 2'b10;
                else                        e.illegal = 1;
            end
            default: e.illegal = 1;
        endcase
        if (e.illegal) begin
            z = '{default: '0};
            z.pc = e.pc; z.rd = e.rd; z.rs1 = e.rs1; z.rs2 = e.rs2; z.illegal = 1;
            e = z;
        end
        return e;
    endfunction

    task automatic check_bundle();
        check("dec_valid", dec_valid_o, exp_q.size() != 0);
        check("halted", halted_o, m_halt);
        if (exp_q.size() != 0) begin
            check("pc", pc_o, exp_q[0].pc);
            check("rd", rd_o, exp_q[0].rd);
            check("rs1", rs1_o, exp_q[0].rs1);
            check("rs2", rs2_o, exp_q[0].rs2);
            check("en", {rd_en_o, rs1_en_o, rs2_en_o}, {exp_q[0].rd_en, exp_q[0].rs1_en, exp_q[0].rs2_en});
            check("mem", {memread_o, memwrite_o, memwid_o}, {exp_q[0].memread, exp_q[0].memwrite, exp_q[0].memwid});
            check("brty", brty_o, exp_q[0].brty);
            check("alu_op", alu_op_o, exp_q[0].alu);
            check("src2_imm", alu_src2_imm_o, exp_q[0].src2);
            check("flow", {branch_o, jal_o, jalr_o, auipc_o},
                  {exp_q[0].branch, exp_q[0].jal, exp_q[0].jalr, exp_q[0].auipc});
            check("imm", imm_o, exp_q[0].imm);
            check("illegal", illegal_o, exp_q[0].illegal);
            check("env", env_o, exp_q[0].env);
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check after.
    task automatic cycle();
        bit   exp_ready, acc, was_valid;
        exp_t e;
        #2;
        exp_ready = !m_halt && (exp_q.size() == 0 || dec_ready_i) && !flush_i;
        check("inst_ready", inst_ready_o, exp_ready);
        acc = inst_valid_i && exp_ready;
        @(posedge clk);
        was_valid = exp_q.size() != 0;
        if (flush_i) begin
            exp_q.delete();
            m_halt = 1'b0;
        end else begin
            if (was_valid && dec_ready_i) void'(exp_q.pop_front());
            if (acc) begin
                e = ref_decode(inst_i, pc_i, 1'b1);
                exp_q.push_back(e);
                if (e.illegal || e.env != 2'b00) m_halt = 1'b1;
            end
        end
        #1;
        check_bundle();
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [63:0] pc,
                         input bit rdy, input bit fl);
        inst_valid_i = v; inst_i = w; pc_i = pc; dec_ready_i = rdy; flush_i = fl;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[12];
        logic [31:0] r;
        int k;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h13};
        r = $urandom;
        k = $urandom_range(0, 14);
        if (k < 12) return {r[31:7], ops[k]};
        if (k == 12) return r;
        if (k == 13) return ($urandom_range(0, 1) != 0) ? 32'h00000073 : 32'h00100073;
        return {r[31:7], 7'h73};
    endfunction

    initial begin
        int cnt;
        // Reset state
        #12;
        check("rst_dec_valid", dec_valid_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_imm", imm_o, 0);
        check("rst_alu", alu_op_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x1,x0,5
        drive(1, 32'h00500093, 64'h1000, 1, 0); cycle();
        check("addi_valid", dec_valid_o, 1);
        check("addi_rd", rd_o, 1);
        check("addi_en", {rd_en_o, rs1_en_o}, 2'b11);
        check("addi_imm", imm_o, 5);
        check("addi_alu", alu_op_o, 0);
        check("addi_src2", alu_src2_imm_o, 1);
        drive(0, 0, 0, 1, 0); cycle();

        // beq held under back-pressure, next inst offered meanwhile
        drive(1, 32'hFE208EE3, 64'h2000, 0, 0); cycle();
        drive(1, 32'h00500093, 64'h2004, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("beq_imm", imm_o, 64'hFFFFFFFFFFFFFFFC);
            check("beq_blocked", inst_ready_o, 0);
        end
        dec_ready_i = 1; cycle();
        drive(0, 0, 0, 1, 0); cycle();

        // lui / addw on both RV64 and RV32 configurations
        drive(1, 32'h123452B7, 64'h3000, 1, 0); cycle();
        check("lui_imm", imm_o, 64'h0000_0000_1234_5000);
        check("lui_alu", alu_op_o, 10);
        drive(1, 32'h002081BB, 64'h3004, 1, 0); cycle();
        check("addw_alu", alu_op_o, 11);
        check("addw_legal", illegal_o, 0);
        check("addw_rv32_illegal", r32_illegal, 1);
        drive(0, 0, 0, 1, 1); cycle();
        flush_i = 0;

        // ecall halts, flush recovers, then the pending addi is taken
        drive(1, 32'h00000073, 64'h4000, 1, 0); cycle();
        check("ecall_env", env_o, 2'b01);
        check("ecall_halted", halted_o, 1);
        drive(1, 32'h00500093, 64'h4004, 1, 0); cycle();
        check("halt_ready", inst_ready_o, 0);
        flush_i = 1; cycle();
        check("flush_valid", dec_valid_o, 0);
        check("flush_halted", halted_o, 0);
        flush_i = 0; cycle();
        check("post_flush_valid", dec_valid_o, 1);
        check("post_flush_pc", pc_o, 64'h4004);
        drive(0, 0, 0, 1, 0); cycle();

        // all-ones word, ebreak
        drive(1, 32'hFFFFFFFF, 64'h5000, 1, 0); cycle();
        check("ill_flag", illegal_o, 1);
        check("ill_ctrl", {rd_en_o, rs1_en_o, rs2_en_o, memread_o, memwrite_o, branch_o, jal_o, jalr_o,
                           auipc_o, alu_src2_imm_o, alu_op_o, env_o}, 0);
        check("ill_halted", halted_o, 1);
        drive(0, 0, 0, 1, 1); cycle();
        drive(1, 32'h00100073, 64'h5004, 1, 0); cycle();
        check("ebreak_env", env_o, 2'b10);
        drive(0, 0, 0, 1, 1); cycle();
        flush_i = 0;

        // 8 back-to-back addi
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, {12'd5, 5'd0, 3'b000, 5'(i + 1), 7'h13}, 64'h6000 + 64'(4 * i), 1, 0);
            cycle();
            if (dec_valid_o === 1'b1) cnt++;
        end
        check("stream_valid_cycles", cnt, 8);

        // async reset mid-stream
        drive(1, 32'h00500093, 64'h7000, 1, 0); cycle();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", dec_valid_o, 0);
        check("async_rst_halted", halted_o, 0);
        exp_q.delete();
        m_halt = 1'b0;
        inst_valid_i = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            inst_valid_i = ($urandom_range(0, 3) != 0);
            dec_ready_i  = ($urandom_range(0, 9) < 7);
            flush_i      = ($urandom_range(0, 15) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            inst_i       = rand_inst();
            pc_i         = {$urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
